// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_regfile
//  Purpose  : WB-stage consumer of the MEM/WB pipeline register. Extracts load
//             data, selects the final writeback value, commits it into a
//             32x32 register file (x0 hardwired to zero), serves two
//             combinational ID read ports with write-through bypass, exports
//             the writeback value/enable for forwarding and counts commits.
//  Revision : 1.0  initial release
// ============================================================================
module writeback_regfile #(
   parameter int XLEN = 32,
   parameter int PC_W = 20,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [PC_W-1:0] WB_PCplus4,
   input  logic            WB_cntl_RegWrite,
   input  logic [2:0]      WB_sel_MemToReg,
   input  logic [2:0]      WB_funct,
   input  logic [XLEN-1:0] WB_ReadMemData,
   input  logic [XLEN-1:0] WB_ALUResult,
   input  logic [4:0]      WB_WriteRegNum,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [31:0]     wb_count
);

   // Result-select encodings; everything not listed falls back to the ALU result
   localparam logic [2:0] c_SEL_LOAD = 3'b001;
   localparam logic [2:0] c_SEL_PC4  = 3'b100;

   // Load funct3 encodings
   localparam logic [2:0] c_LB  = 3'b000;
   localparam logic [2:0] c_LH  = 3'b001;
   localparam logic [2:0] c_LBU = 3'b100;
   localparam logic [2:0] c_LHU = 3'b101;

   // x0 has no storage; entries 1..NREG-1 only
   logic [XLEN-1:0] r_regs [NREG-1:1];
   logic [31:0]     r_wb_count;

   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_load;
   logic [XLEN-1:0] w_wb_data;
   logic            w_we;

   // Load lane extraction: byte lane from addr[1:0], halfword lane from addr[1]
   // (a misaligned halfword simply uses addr[1]; no trap is raised here)
   always_comb begin
      w_byte = WB_ReadMemData[{WB_ALUResult[1:0], 3'b000} +: 8];
      w_half = WB_ALUResult[1] ? WB_ReadMemData[31:16] : WB_ReadMemData[15:0];
      case (WB_funct)
         c_LB    : w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
         c_LBU   : w_load = {{(XLEN-8){1'b0}}, w_byte};
         c_LH    : w_load = {{(XLEN-16){w_half[15]}}, w_half};
         c_LHU   : w_load = {{(XLEN-16){1'b0}}, w_half};
         default : w_load = WB_ReadMemData;
      endcase
   end

   // Final writeback value select (zero latency)
   always_comb begin
      case (WB_sel_MemToReg)
         c_SEL_LOAD : w_wb_data = w_load;
         c_SEL_PC4  : w_wb_data = {{(XLEN-PC_W){1'b0}}, WB_PCplus4};
         default    : w_wb_data = WB_ALUResult;
      endcase
   end

   // Writes to x0 are not real commits: they neither store nor count
   assign w_we = WB_cntl_RegWrite && (WB_WriteRegNum != 5'd0);

   // Register file commit and commit counter; reset discards any pending write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_wb_count <= '0;
      end else if (w_we) begin
         r_regs[WB_WriteRegNum] <= w_wb_data;
         r_wb_count             <= r_wb_count + 32'd1;
      end
   end

   // Read port 1: x0 reads zero, bypass suppressed during reset, else write-through
   always_comb begin
      if (rs1_addr == 5'd0 || !reset_n) begin
         rs1_data = '0;
      end else if (w_we && rs1_addr == WB_WriteRegNum) begin
         rs1_data = w_wb_data;
      end else begin
         rs1_data = r_regs[rs1_addr];
      end
   end

   // Read port 2: same rules as port 1
   always_comb begin
      if (rs2_addr == 5'd0 || !reset_n) begin
         rs2_data = '0;
      end else if (w_we && rs2_addr == WB_WriteRegNum) begin
         rs2_data = w_wb_data;
      end else begin
         rs2_data = r_regs[rs2_addr];
      end
   end

   assign wb_data  = w_wb_data;
   assign wb_we    = w_we;
   assign wb_rd    = WB_WriteRegNum;
   assign wb_count = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_regfile
//  Purpose  : Self-checking bench for writeback_regfile: directed scenarios
//             with literal expectations plus randomized traffic checked every
//             cycle against a plain array/counter reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_writeback_regfile;

   logic        clk;
   logic        reset_n;
   logic [19:0] WB_PCplus4;
   logic        WB_cntl_RegWrite;
   logic [2:0]  WB_sel_MemToReg;
   logic [2:0]  WB_funct;
   logic [31:0] WB_ReadMemData;
   logic [31:0] WB_ALUResult;
   logic [4:0]  WB_WriteRegNum;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_count;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_count;

   writeback_regfile #(.XLEN(32), .PC_W(20), .NREG(32)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .WB_PCplus4       (WB_PCplus4),
      .WB_cntl_RegWrite (WB_cntl_RegWrite),
      .WB_sel_MemToReg  (WB_sel_MemToReg),
      .WB_funct         (WB_funct),
      .WB_ReadMemData   (WB_ReadMemData),
      .WB_ALUResult     (WB_ALUResult),
      .WB_WriteRegNum   (WB_WriteRegNum),
      .rs1_addr         (rs1_addr),
      .rs2_addr         (rs2_addr),
      .rs1_data         (rs1_data),
      .rs2_data         (rs2_data),
      .wb_data          (wb_data),
      .wb_we            (wb_we),
      .wb_rd            (wb_rd),
      .wb_count         (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load();
      int          a;
      logic [31:0] b;
      logic [31:0] h;
      a = int'(WB_ALUResult[1:0]);
      b = (WB_ReadMemData >> (8 * a)) & 32'h0000_00FF;
      h = (WB_ReadMemData >> (16 * int'(WB_ALUResult[1]))) & 32'h0000_FFFF;
      case (WB_funct)
         3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'b101:  return h;
         default: return WB_ReadMemData;
      endcase
   endfunction

   function automatic logic [31:0] m_wb();
      if (WB_sel_MemToReg == 3'b001) return m_load();
      if (WB_sel_MemToReg == 3'b100) return {12'd0, WB_PCplus4};
      return WB_ALUResult;
   endfunction

   function automatic logic m_we();
      return WB_cntl_RegWrite && (WB_WriteRegNum != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] addr);
      if (addr == 5'd0 || !reset_n) return 32'd0;
      if (m_we() && addr == WB_WriteRegNum) return m_wb();
      return m_regs[addr];
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;
   endtask

   task automatic m_commit();
      if (reset_n && m_we()) begin
         m_regs[WB_WriteRegNum] = m_wb();
         m_count                = m_count + 32'd1;
      end
   endtask

   // ---------------- checking ----------------
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("rs1_data", rs1_data, m_read(rs1_addr));
         cmp("rs2_data", rs2_data, m_read(rs2_addr));
         cmp("wb_data",  wb_data,  m_wb());
         cmp("wb_we",    {31'd0, wb_we}, {31'd0, m_we()});
         cmp("wb_rd",    {27'd0, wb_rd}, {27'd0, WB_WriteRegNum});
         cmp("wb_count", wb_count, m_count);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic we, input logic [4:0] rd, input logic [2:0] sel,
                         input logic [2:0] fn, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [19:0] pc, input logic [4:0] a1, input logic [4:0] a2);
      WB_cntl_RegWrite = we;
      WB_WriteRegNum   = rd;
      WB_sel_MemToReg  = sel;
      WB_funct         = fn;
      WB_ALUResult     = alu;
      WB_ReadMemData   = mem;
      WB_PCplus4       = pc;
      rs1_addr         = a1;
      rs2_addr         = a2;
   endtask

   // Advance one rising edge, update the model with what was committed, then
   // leave time for the next inputs to be driven away from the edge
   task automatic step();
      @(posedge clk);
      m_commit();
      #1;
   endtask

   // Load cases: funct, address low bits, expected extracted value
   logic [2:0]  ld_fn  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
   logic [31:0] ld_adr [5] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h0};
   logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1,
                               32'h0000_7F02, 32'h80F1_7F02};

   initial begin
      m_clear();
      reset_n = 1'b0;
      set_in(1'b0, 5'd0, 3'd0, 3'd0, 32'd0, 32'd0, 20'd0, 5'd0, 5'd0);
      chk_en = 1'b1;
      step();
      step();
      reset_n = 1'b1;

      // Reset contents: all addresses on both ports read zero
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         @(negedge clk);
         step();
      end
      @(negedge clk);
      cmp("lit_reset_count", wb_count, 32'd0);
      step();

      // Bypass of a same-cycle write, then stored value after the edge
      set_in(1'b1, 5'd5, 3'b000, 3'd0, 32'hDEAD_BEEF, 32'd0, 20'd0, 5'd5, 5'd5);
      @(negedge clk);
      cmp("lit_bypass_rs1", rs1_data, 32'hDEAD_BEEF);
      cmp("lit_bypass_rs2", rs2_data, 32'hDEAD_BEEF);
      step();
      WB_cntl_RegWrite = 1'b0;
      @(negedge clk);
      cmp("lit_stored_x5", rs1_data, 32'hDEAD_BEEF);
      cmp("lit_count_1", wb_count, 32'd1);
      step();

      // Load extraction into x7
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, 5'd7, 3'b001, ld_fn[k], ld_adr[k], 32'h80F1_7F02, 20'd0, 5'd7, 5'd0);
         @(negedge clk);
         cmp("lit_load_wbdata", wb_data, ld_exp[k]);
         cmp("lit_load_model", m_wb(), ld_exp[k]);
         step();
         WB_cntl_RegWrite = 1'b0;
         @(negedge clk);
         cmp("lit_load_x7", rs1_data, ld_exp[k]);
         step();
      end

      // Write to x0 is dropped and not counted
      set_in(1'b1, 5'd0, 3'b000, 3'd0, 32'h0000_1234, 32'd0, 20'd0, 5'd0, 5'd0);
      @(negedge clk);
      cmp("lit_x0_we", {31'd0, wb_we}, 32'd0);
      cmp("lit_x0_read", rs1_data, 32'd0);
      step();
      WB_cntl_RegWrite = 1'b0;
      @(negedge clk);
      cmp("lit_x0_count", wb_count, 32'd6);
      step();

      // PC+4 select and branch-target select
      set_in(1'b1, 5'd1, 3'b100, 3'd0, 32'hFFFF_FFFF, 32'd0, 20'hABCDE, 5'd1, 5'd0);
      step();
      set_in(1'b1, 5'd2, 3'b011, 3'd0, 32'h0040_0010, 32'd0, 20'hABCDE, 5'd1, 5'd2);
      step();
      WB_cntl_RegWrite = 1'b0;
      @(negedge clk);
      cmp("lit_pc4_x1", rs1_data, 32'h000A_BCDE);
      cmp("lit_br_x2",  rs2_data, 32'h0040_0010);
      step();

      // Reset between edges clears storage at once and discards a pending write
      set_in(1'b1, 5'd3, 3'b000, 3'd0, 32'h55, 32'd0, 20'd0, 5'd3, 5'd4);
      step();
      set_in(1'b1, 5'd4, 3'b000, 3'd0, 32'h99, 32'd0, 20'd0, 5'd3, 5'd4);
      @(negedge clk);
      cmp("lit_x3_pre", rs1_data, 32'h55);
      #2;
      reset_n = 1'b0;
      m_clear();
      #1;
      cmp("lit_x3_reset", rs1_data, 32'd0);
      cmp("lit_count_reset", wb_count, 32'd0);
      step();
      reset_n = 1'b1;
      set_in(1'b1, 5'd4, 3'b000, 3'd0, 32'h77, 32'd0, 20'd0, 5'd4, 5'd3);
      step();
      WB_cntl_RegWrite = 1'b0;
      @(negedge clk);
      cmp("lit_after_reset_count", wb_count, 32'd1);
      cmp("lit_after_reset_x4", rs1_data, 32'h77);
      cmp("lit_after_reset_x3", rs2_data, 32'd0);

      // Counter wrap: preload all-ones, commit one write
      #1;
      force dut.r_wb_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_wb_count;
      m_count = 32'hFFFF_FFFF;
      set_in(1'b1, 5'd9, 3'b000, 3'd0, 32'h1, 32'd0, 20'd0, 5'd9, 5'd0);
      step();
      WB_cntl_RegWrite = 1'b0;
      @(negedge clk);
      cmp("lit_count_wrap", wb_count, 32'd0);
      step();

      // Randomized traffic with occasional mid-run resets
      for (int n = 0; n < 400; n++) begin
         set_in(($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31)),
                3'($urandom), 3'($urandom), $urandom, $urandom, 20'($urandom),
                5'($urandom), 5'($urandom));
         if ($urandom_range(0, 2) == 0) rs1_addr = WB_WriteRegNum;
         if ($urandom_range(0, 2) == 0) rs2_addr = WB_WriteRegNum;
         if ($urandom_range(0, 59) == 0) begin
            reset_n = 1'b0;
            m_clear();
         end
         step();
         reset_n = 1'b1;
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
